// File: rtl/rv32_pkg.sv
// Shared types for the rv32 memory arbiter: FSM state encoding and owner encoding.
package rv32_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/rv32_arb_watchdog.sv
// WAIT-phase watchdog: cleared on WAIT entry, counts WAIT cycles, flags the TIMEOUT-th one.
// TIMEOUT=0 ties expire low.
module rv32_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused = ^{clk, reset_n, clear, enable};
    assign expire = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (clear) begin
        cnt <= '0;
      end else if (enable && (cnt != MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end

    // cnt counts completed WAIT cycles, so LAST marks the TIMEOUT-th one.
    assign expire = enable && (cnt == LAST);
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbitrates the core's fetch (I) and load/store (D) ports onto one single-ported memory bus.
// Build option RV32_ARB_RR_EN selects round-robin; default is fixed priority with D over I.
module rv32_mem_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_done,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  state_e        state;
  logic          owner;
  logic          i_elig, d_elig, any_elig, pick;
  logic          wd_clear, wd_en, wd_expire;
  logic          comp, comp_err;
  logic [DW-1:0] comp_data;

  // A requester still showing its done pulse is not a new request.
  assign i_elig   = i_req & ~i_done;
  assign d_elig   = d_req & ~d_done;
  assign any_elig = i_elig | d_elig;

`ifdef RV32_ARB_RR_EN
  logic last_owner;

  assign pick = (i_elig && d_elig) ? ~last_owner : (d_elig ? OWN_D : OWN_I);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWN_I;
    end else if ((state == S_IDLE) && any_elig) begin
      last_owner <= pick;
    end
  end
`else
  assign pick = d_elig ? OWN_D : OWN_I;
`endif

  assign wd_clear = (state == S_REQ) && m_gnt;
  assign wd_en    = (state == S_WAIT);

  rv32_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  // A response in the expiry cycle wins over the timeout.
  assign comp      = ((state == S_REQ) && m_gnt && m_rvalid) ||
                     ((state == S_WAIT) && (m_rvalid || wd_expire));
  assign comp_err  = (state == S_WAIT) && !m_rvalid && wd_expire;
  assign comp_data = (comp_err || m_we) ? '0 : m_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      owner   <= OWN_I;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      i_rdata <= '0;
      i_done  <= 1'b0;
      i_err   <= 1'b0;
      d_rdata <= '0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (any_elig) begin
            owner <= pick;
            m_req <= 1'b1;
            state <= S_REQ;
            if (pick == OWN_D) begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_be    <= d_be;
            end else begin
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_be    <= '1;
            end
          end
        end
        S_REQ: begin
          if (m_gnt) begin
            m_req <= 1'b0;
            state <= m_rvalid ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (comp) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (comp) begin
        if (owner == OWN_D) begin
          d_done  <= 1'b1;
          d_err   <= comp_err;
          d_rdata <= comp_data;
        end else begin
          i_done  <= 1'b1;
          i_err   <= comp_err;
          i_rdata <= comp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Scoreboard bench for rv32_mem_arbiter: directed reset/fetch cases, then random I/D traffic
// against a memory model that predicts completions from arbitration and watchdog rules.
module tb_rv32_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_done, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  logic        rand_on = 1'b0;
  logic        dir_gnt, dir_rvalid, mem_gnt, mem_rvalid;
  logic [31:0] dir_rdata, mem_rdata;

  assign m_gnt    = rand_on ? mem_gnt    : dir_gnt;
  assign m_rvalid = rand_on ? mem_rvalid : dir_rvalid;
  assign m_rdata  = rand_on ? mem_rdata  : dir_rdata;

  rv32_mem_arbiter #(
    .AW(32),
    .DW(32),
    .TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_be    (d_be),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_err   (d_err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_gnt   (m_gnt),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          own;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t sbq[$];

  bit          snap_i, snap_d;
  logic [31:0] i_hold, d_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Winner from the set of pending requesters; fixed priority prefers D.
  function automatic bit model_pick(input bit ie, input bit de, input bit last);
`ifdef RV32_ARB_RR_EN
    if (ie && de) return !last;
`endif
    return de;
  endfunction

  // Monitor: snapshot pending requests and pop/compare completions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      snap_i = i_req && !i_done;
      snap_d = d_req && !d_done;
      if (rand_on) begin
        if (i_done && d_done) chk("both_done", 32'(i_done & d_done), 32'd0);
        if (i_done || d_done) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done at cycle %0d, required no completion", cyc);
          end else begin
            e = sbq.pop_front();
            chk("done_owner", 32'(d_done), 32'(e.own));
            chk("done_err", 32'(d_done ? d_err : i_err), 32'(e.err));
            chk("done_rdata", d_done ? d_rdata : i_rdata, e.rdata);
            chk("done_cycle", 32'(cyc), 32'(e.due));
            if (d_done) d_hold = e.rdata;
            else i_hold = e.rdata;
          end
        end else begin
          if (sbq.size() > 0 && cyc > sbq[0].due) begin
            checks++;
            failures++;
            $display("FAIL missing_done: got no done, required one at cycle %0d", sbq[0].due);
            void'(sbq.pop_front());
          end
          chk("i_rdata_hold", i_rdata, i_hold);
          chk("d_rdata_hold", d_rdata, d_hold);
        end
      end
    end
  end

  // Memory model: grants with random latency, answers or drops, and predicts each completion.
  initial begin
    bit          in_req = 0, busy = 0, stray = 0, last = 0;
    bit          e_own, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    int          cnt = 0, gdel = 0, rdly = 0, gcyc = 0;
    mem_gnt = 0;
    mem_rvalid = 0;
    mem_rdata = 0;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = $urandom;
      if (rand_on) begin
        if (stray) begin
          mem_rvalid = 1;
          stray = 0;
        end
        if (busy) chk("m_req_low_in_wait", 32'(m_req), 32'd0);
        if (!busy && m_req) begin
          if (!in_req) begin
            in_req = 1;
            cnt = 0;
            gdel = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 2);
            if (!snap_i && !snap_d) begin
              checks++;
              failures++;
              $display("FAIL spurious_req: got m_req=1, required no request pending");
            end
            e_own = model_pick(snap_i, snap_d, last);
            last = e_own;
            if (e_own) begin
              e_we = d_we;
              e_addr = d_addr;
              e_wdata = d_wdata;
              e_be = d_be;
            end else begin
              e_we = 0;
              e_addr = i_addr;
              e_wdata = 0;
              e_be = 4'hF;
            end
          end
          chk("m_we", 32'(m_we), 32'(e_we));
          chk("m_addr", m_addr, e_addr);
          chk("m_be", 32'(m_be), 32'(e_be));
          if (e_own) chk("m_wdata", m_wdata, e_wdata);
          if (cnt == gdel) begin
            mem_gnt = 1;
            in_req = 0;
            busy = 1;
            gcyc = cyc;
            rdly = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO);
          end else begin
            cnt++;
            if ($urandom_range(0, 3) == 0) mem_rvalid = 1;
          end
        end
        if (busy) begin
          if (rdly >= 0 && cyc - gcyc == rdly) begin
            mem_rvalid = 1;
            mem_rdata = e_we ? $urandom : rd_fn(e_addr);
            sbq.push_back('{e_own, 1'b0, e_we ? 32'd0 : rd_fn(e_addr), cyc + 1});
            busy = 0;
          end else if (rdly < 0 && cyc - gcyc == TO) begin
            sbq.push_back('{e_own, 1'b1, 32'd0, cyc + 1});
            busy = 0;
            stray = 1;
          end
        end
      end
    end
  end

  task automatic run_i(input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      i_req = 1;
      i_addr = $urandom & 32'hFFFF_FFFC;
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        got = i_done;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL i_wait: got no i_done within 200 cycles, required completion");
      end
      @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) begin
        i_req = 0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    i_req = 0;
  endtask

  task automatic run_d(input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      d_req = 1;
      d_we = 1'($urandom_range(0, 1));
      d_addr = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      d_be = 4'($urandom_range(1, 15));
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        got = d_done;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL d_wait: got no d_done within 200 cycles, required completion");
      end
      @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) begin
        d_req = 0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    d_req = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required completion of run");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset_n = 0;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    dir_gnt = 0; dir_rvalid = 0; dir_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_dones", 32'({i_done, d_done, i_err, d_err}), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    reset_n = 1;

    // Fetch at 0x100: gnt at once, response two cycles after gnt.
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h100;
    @(posedge clk); #1;
    chk("t1_m_req", 32'(m_req), 32'd1);
    chk("t1_m_addr", m_addr, 32'h100);
    chk("t1_m_be", 32'(m_be), 32'hF);
    chk("t1_m_we", 32'(m_we), 32'd0);
    dir_gnt = 1;
    @(posedge clk); #1;
    dir_gnt = 0;
    chk("t1_m_req_dropped", 32'(m_req), 32'd0);
    @(posedge clk); #1;
    chk("t1_no_early_done", 32'(i_done), 32'd0);
    dir_rvalid = 1; dir_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    dir_rvalid = 0;
    chk("t1_i_done", 32'(i_done), 32'd1);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_i_err", 32'(i_err), 32'd0);
    chk("t1_d_done", 32'(d_done), 32'd0);
    i_req = 0;
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(i_done), 32'd0);
    chk("t1_rdata_hold", i_rdata, 32'hDEADBEEF);

    // Async reset while waiting for a response.
    i_req = 1; i_addr = 32'h104;
    @(posedge clk); #1;
    dir_gnt = 1;
    @(posedge clk); #1;
    dir_gnt = 0;
    @(posedge clk); #4;
    reset_n = 0;
    #1;
    chk("t6_m_req", 32'(m_req), 32'd0);
    chk("t6_m_addr", m_addr, 32'd0);
    chk("t6_i_rdata", i_rdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    chk("t6_re_req", 32'(m_req), 32'd1);
    chk("t6_re_addr", m_addr, 32'h104);
    dir_gnt = 1; dir_rvalid = 1; dir_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dir_gnt = 0; dir_rvalid = 0;
    chk("t4_direct_done", 32'(i_done), 32'd1);
    chk("t4_direct_rdata", i_rdata, 32'hCAFEF00D);
    i_req = 0;
    @(posedge clk); #1;

    i_hold = 32'hCAFEF00D;
    d_hold = 32'd0;
    rand_on = 1;
    fork
      run_i(60);
      run_d(60);
    join
    repeat (20) @(posedge clk);
    #1;
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
